spiio_slave: RTL and testbench
==============================

// Module: spiio_slave
// PURPOSE
//  SPI responder (mode 0, MSB first, 8/16-bit frames) with a CPU byte-register interface.
//  Lets the board act as the target of an external SPI master, such as a second board's SD/SPI host port.
//  Sits on the superio bus beside the SPI master; uses the same register-access style: AD/DI/DO/rw/cs.
// PARAMETERS
//  SYNC_STAGES  2      flops in each SCK/MOSI/SS input synchronizer (>=2)
//  FILL         8'hFF  byte shifted out on MISO when no TX data is committed (16b: {FILL,FILL})
// PORTS
//  clk      in   1  system clock; all logic on posedge clk
//  rst      in   1  asynchronous, active-low reset
//  AD       in   3  register address
//  DI       in   8  write data
//  DO       out  8  read data, registered
//  rw       in   1  1=read, 0=write
//  cs       in   1  register select
//  irq      out  1  level interrupt, active high
//  ssck     in   1  SPI clock from master
//  smosi    in   1  SPI data from master
//  smiso    out  1  SPI data to master
//  smiso_oe out  1  MISO output enable (1 while selected and EN=1)
//  sss      in   1  SPI select, active low
// BEHAVIOUR
//  Registers:
//   $0  R: RX[15:8]; W: TX[15:8]
//   $1  R: RX[7:0], clears RDY; W: TX[7:0], commits TX buffer and clears TXE
//   $2  R: RDY|OVR|TXE|16B|BSY|SEL|0|EN; W: bit6=1 clears OVR, bit4 sets 16B, bit0 sets EN
//   $3  R/W: IE, bit0=RDY irq enable, bit1=TXE irq enable; other bits read 0
//  Read timing: DO is updated on the posedge when cs&rw are high, and is valid the next cycle.
//  Reset values: DO=0, smiso=1, smiso_oe=0, irq=0, RDY=0, OVR=0, TXE=1, 16B=0, EN=0, IE=0.
//   RX=0, TX=0, bit_cnt=0, BSY=0.
//  Input sync: ssck, smosi and sss each pass through SYNC_STAGES flops; edges come from the last stage vs one more flop.
//   Pin-to-action latency is SYNC_STAGES+1 clk.
//   Master SCK must be <= clk/8; each SCK phase must be >= 4 clk.
//  State machine (clk domain):
//   IDLE   -> LOAD   on synced sss falling edge with EN=1
//   LOAD   (1 clk)   shreg <= TXE ? fill : TXbuf; TXE<=1; bit_cnt <= 16B?16:8
//                    smiso<=shreg MSB; BSY=1; -> SHIFT
//   SHIFT  SCK rise: rxsh <= {rxsh, smosi}; bit_cnt--
//          SCK fall: if bit_cnt != frame length, shift shreg left (fill 1), smiso <= new MSB
//          bit_cnt reaches 0 -> DONE
//   DONE   (1 clk)   RX <= rxsh; if RDY was already 1, set OVR; RDY<=1
//                    sss still low -> LOAD (back-to-back frame); else -> IDLE
//   any state: synced sss high -> IDLE, bit_cnt=0, BSY=0, smiso=1
//              a partial frame is discarded: RX, RDY and OVR are unchanged
//  16B is sampled only in LOAD; changing it mid-frame affects the next frame only.
//  In 8-bit mode RX[15:8] reads 0 and only TX[7:0] is shifted.
//  Clearing EN mid-frame aborts as if sss went high; smiso_oe drops the same cycle.
//  SEL = synced ~sss.
//  irq = (RDY & IE[0]) | (TXE & IE[1]), combinational from registered flags.
//  Simultaneous events:
//   $1 write in the LOAD cycle: shreg takes the old buffer (or fill if TXE was set); the buffer takes DI; TXE ends 0
//   $1 read in the DONE cycle: RDY ends 1; OVR is not set
//   OVR-clear write in the DONE cycle with an overrun: OVR ends 1 (set wins)
//  Reset asserted mid-frame: immediate return to reset values; smiso=1.
// TESTING
//  1. Reset, EN=1, write $1=A5; master sends 8-bit frame 3C (clk/8).
//     -> MISO carries A5; RX lo=3C; RDY=1, TXE=1; reading $1 clears RDY.
//  2. 16B=1, write $0=12, $1=34; master sends BEEF.
//     -> MISO=1234; $0=BE, $1=EF; irq rises with IE=1 at DONE.
//  3. No TX write; two back-to-back 8-bit frames 01, 02 with sss held low, no CPU read.
//     -> MISO=FF,FF; RX=02; OVR=1; writing $2 with bit6=1 clears OVR.
//  4. sss deasserted after 5 SCK rises.
//     -> RX/RDY unchanged, BSY=0, smiso=1; next full frame is received correctly.
//  5. Write to $1 aligned to the LOAD cycle.
//     -> shifted data = previous buffer; new value is sent in the following frame; TXE=0 after LOAD.
//  6. rst pulsed low mid-frame.
//     -> all registers/outputs at reset values within the same cycle; EN=0 ignores a later sss assertion.

Source files
------------

// File: rtl/spiio_slave.sv
// SPI mode-0 responder (MSB first, 8/16-bit frames) with a byte-wide CPU register port.
// SCK/MOSI/SS are oversampled in the clk domain; all shifting is driven by synced edges.
module spiio_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL        = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       ssck,
    input  logic       smosi,
    output logic       smiso,
    output logic       smiso_oe,
    input  logic       sss
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

    state_t r_state, w_next;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync, r_ss_sync;
    logic        r_sck_d, r_ss_d;
    logic [15:0] r_rx, r_tx, r_shreg, r_rxsh;
    logic        r_rdy, r_ovr, r_txe, r_16b, r_en, r_frame16, r_smiso;
    logic [1:0]  r_ie;
    logic [4:0]  r_bitcnt;
    logic [7:0]  r_do;

    logic        w_sck, w_mosi, w_ss;
    logic        w_sck_rise, w_sck_fall, w_ss_fall;
    logic        w_load, w_done, w_abort;
    logic        w_wr, w_rd1, w_wr1, w_wr2;
    logic [15:0] w_load_val;
    logic [4:0]  w_len;
    logic [7:0]  w_status;

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss       = r_ss_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;
    assign w_ss_fall  = ~w_ss & r_ss_d;

    assign w_wr  = cs & ~rw;
    assign w_wr1 = w_wr & (AD == 3'd1);
    assign w_wr2 = w_wr & (AD == 3'd2);
    assign w_rd1 = cs & rw & (AD == 3'd1);

    // Uncommitted TX sends FILL; 8-bit frames only use the low TX byte, placed at the MSB end.
    assign w_load_val = r_txe ? {FILL, FILL} : (r_16b ? r_tx : {r_tx[7:0], FILL});
    assign w_len      = r_frame16 ? 5'd16 : 5'd8;
    assign w_status   = {r_rdy, r_ovr, r_txe, r_16b, (r_state != ST_IDLE), ~w_ss, 1'b0, r_en};

    assign DO       = r_do;
    assign smiso    = r_smiso;
    assign smiso_oe = ~w_ss & r_en;
    assign irq      = (r_rdy & r_ie[0]) | (r_txe & r_ie[1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_sck_d     <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], ssck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], smosi};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], sss};
            r_sck_d     <= w_sck;
            r_ss_d      <= w_ss;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // A completed frame is always stored in DONE; only LOAD/SHIFT can be aborted.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_ss_fall && r_en) w_next = ST_LOAD;
            ST_LOAD: begin
                w_load = 1'b1;
                w_next = ST_SHIFT;
            end
            ST_SHIFT: if (w_sck_rise && r_bitcnt == 5'd1) w_next = ST_DONE;
            ST_DONE: begin
                w_done = 1'b1;
                w_next = (!w_ss && r_en) ? ST_LOAD : ST_IDLE;
            end
            default:  w_next = ST_IDLE;
        endcase
        if ((r_state == ST_LOAD || r_state == ST_SHIFT) && (w_ss || !r_en)) begin
            w_abort = 1'b1;
            w_load  = 1'b0;
            w_next  = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx  <= '0;
            r_16b <= 1'b0;
            r_en  <= 1'b0;
            r_ie  <= '0;
            r_rdy <= 1'b0;
            r_ovr <= 1'b0;
            r_txe <= 1'b1;
            r_do  <= '0;
        end else begin
            if (w_wr) begin
                case (AD)
                    3'd0: r_tx[15:8] <= DI;
                    3'd1: r_tx[7:0]  <= DI;
                    3'd2: begin
                        r_16b <= DI[4];
                        r_en  <= DI[0];
                    end
                    3'd3: r_ie <= DI[1:0];
                    default: ;
                endcase
            end
            if (w_wr2 && DI[6])           r_ovr <= 1'b0;
            if (w_done && r_rdy && !w_rd1) r_ovr <= 1'b1;
            if (w_rd1)  r_rdy <= 1'b0;
            if (w_done) r_rdy <= 1'b1;
            if (w_load) r_txe <= 1'b1;
            if (w_wr1)  r_txe <= 1'b0;
            if (cs && rw) begin
                case (AD)
                    3'd0:    r_do <= r_rx[15:8];
                    3'd1:    r_do <= r_rx[7:0];
                    3'd2:    r_do <= w_status;
                    3'd3:    r_do <= {6'd0, r_ie};
                    default: r_do <= 8'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg   <= '0;
            r_rxsh    <= '0;
            r_rx      <= '0;
            r_bitcnt  <= '0;
            r_frame16 <= 1'b0;
            r_smiso   <= 1'b1;
        end else if (w_abort || r_state == ST_IDLE) begin
            r_bitcnt <= '0;
            r_smiso  <= 1'b1;
        end else if (w_load) begin
            r_shreg   <= w_load_val;
            r_smiso   <= w_load_val[15];
            r_bitcnt  <= r_16b ? 5'd16 : 5'd8;
            r_frame16 <= r_16b;
        end else if (r_state == ST_SHIFT) begin
            // The fall right after LOAD precedes any rise of the new frame and must not shift.
            if (w_sck_rise) begin
                r_rxsh   <= {r_rxsh[14:0], w_mosi};
                r_bitcnt <= r_bitcnt - 5'd1;
            end else if (w_sck_fall && r_bitcnt != w_len) begin
                r_shreg <= {r_shreg[14:0], 1'b1};
                r_smiso <= r_shreg[14];
            end
        end else if (w_done) begin
            r_rx <= r_frame16 ? r_rxsh : {8'd0, r_rxsh[7:0]};
        end
    end

endmodule

// File: tb/tb_spiio_slave.sv
// Directed bench for spiio_slave: a behavioural SPI master at clk/8 plus CPU register accesses.
module tb_spiio_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw, cs, irq;
    logic       ssck, smosi, smiso, smiso_oe, sss;

    int checks = 0;
    int errors = 0;

    spiio_slave #(.SYNC_STAGES(2), .FILL(8'hFF)) dut (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs), .irq(irq),
        .ssck(ssck), .smosi(smosi), .smiso(smiso), .smiso_oe(smiso_oe), .sss(sss)
    );

    always #5 clk = ~clk;

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [7:0] v);
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; AD = a;
        @(negedge clk);
        cs = 1'b0; rw = 1'b0;
        v = DO;
    endtask

    task automatic ss_low();
        @(negedge clk);
        sss = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ss_high();
        sss = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Mode 0: MOSI changes while SCK is low; MISO is captured just before each rising edge.
    task automatic spi_bits(input logic [15:0] d, input int n, output logic [15:0] got);
        got = '0;
        for (int i = n - 1; i >= 0; i--) begin
            smosi = d[i];
            repeat (4) @(negedge clk);
            got = {got[14:0], smiso};
            ssck = 1'b1;
            repeat (4) @(negedge clk);
            ssck = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        checks++; if (DO !== 8'h00) begin errors++; $display("FAIL rst_do got %h exp %h", DO, 8'h00); end
        checks++; if (smiso !== 1'b1) begin errors++; $display("FAIL rst_miso got %b exp 1", smiso); end
        checks++; if (smiso_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got %b exp 0", smiso_oe); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
        cpu_rd(3'd2, v);
        checks++; if (v !== 8'h20) begin errors++; $display("FAIL rst_status got %h exp %h", v, 8'h20); end
        cpu_rd(3'd1, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_rxlo got %h exp %h", v, 8'h00); end
        cpu_wr(3'd3, 8'h02);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rst_txe_irq got %b exp 1", irq); end
        cpu_rd(3'd3, v);
        checks++; if (v !== 8'h02) begin errors++; $display("FAIL rst_ie got %h exp %h", v, 8'h02); end
        cpu_wr(3'd3, 8'h00);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq_off got %b exp 0", irq); end
    endtask

    task automatic test_frame8();
        logic [7:0]  v;
        logic [15:0] g;
        cpu_wr(3'd2, 8'h01);
        cpu_wr(3'd1, 8'hA5);
        ss_low();
        checks++; if (smiso_oe !== 1'b1) begin errors++; $display("FAIL f8_oe got %b exp 1", smiso_oe); end
        spi_bits(16'h003C, 8, g);
        checks++; if (g[7:0] !== 8'hA5) begin errors++; $display("FAIL f8_miso got %h exp %h", g[7:0], 8'hA5); end
        ss_high();
        cpu_rd(3'd2, v);
        checks++; if (v !== 8'hA1) begin errors++; $display("FAIL f8_status got %h exp %h", v, 8'hA1); end
        cpu_rd(3'd1, v);
        checks++; if (v !== 8'h3C) begin errors++; $display("FAIL f8_rxlo got %h exp %h", v, 8'h3C); end
        cpu_rd(3'd0, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL f8_rxhi got %h exp %h", v, 8'h00); end
        cpu_rd(3'd2, v);
        checks++; if (v !== 8'h21) begin errors++; $display("FAIL f8_rdy_clr got %h exp %h", v, 8'h21); end
    endtask

    task automatic test_frame16();
        logic [7:0]  v;
        logic [15:0] g;
        cpu_wr(3'd2, 8'h11);
        cpu_wr(3'd3, 8'h01);
        cpu_wr(3'd0, 8'h12);
        cpu_wr(3'd1, 8'h34);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL f16_irq_pre got %b exp 0", irq); end
        ss_low();
        spi_bits(16'hBEEF, 16, g);
        checks++; if (g !== 16'h1234) begin errors++; $display("FAIL f16_miso got %h exp %h", g, 16'h1234); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL f16_irq got %b exp 1", irq); end
        ss_high();
        cpu_rd(3'd0, v);
        checks++; if (v !== 8'hBE) begin errors++; $display("FAIL f16_rxhi got %h exp %h", v, 8'hBE); end
        cpu_rd(3'd1, v);
        checks++; if (v !== 8'hEF) begin errors++; $display("FAIL f16_rxlo got %h exp %h", v, 8'hEF); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL f16_irq_clr got %b exp 0", irq); end
        cpu_wr(3'd3, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  v;
        logic [15:0] g1, g2;
        cpu_wr(3'd2, 8'h01);
        ss_low();
        spi_bits(16'h0001, 8, g1);
        spi_bits(16'h0002, 8, g2);
        ss_high();
        checks++; if (g1[7:0] !== 8'hFF) begin errors++; $display("FAIL b2b_miso1 got %h exp %h", g1[7:0], 8'hFF); end
        checks++; if (g2[7:0] !== 8'hFF) begin errors++; $display("FAIL b2b_miso2 got %h exp %h", g2[7:0], 8'hFF); end
        cpu_rd(3'd2, v);
        checks++; if (v !== 8'hE1) begin errors++; $display("FAIL b2b_status got %h exp %h", v, 8'hE1); end
        cpu_rd(3'd1, v);
        checks++; if (v !== 8'h02) begin errors++; $display("FAIL b2b_rx got %h exp %h", v, 8'h02); end
        cpu_wr(3'd2, 8'h41);
        cpu_rd(3'd2, v);
        checks++; if (v !== 8'h21) begin errors++; $display("FAIL b2b_ovr_clr got %h exp %h", v, 8'h21); end
    endtask

    task automatic test_abort();
        logic [7:0]  v;
        logic [15:0] g;
        ss_low();
        spi_bits(16'h0015, 5, g);
        ss_high();
        checks++; if (smiso !== 1'b1) begin errors++; $display("FAIL abort_miso got %b exp 1", smiso); end
        cpu_rd(3'd2, v);
        checks++; if (v !== 8'h21) begin errors++; $display("FAIL abort_status got %h exp %h", v, 8'h21); end
        cpu_rd(3'd1, v);
        checks++; if (v !== 8'h02) begin errors++; $display("FAIL abort_rx got %h exp %h", v, 8'h02); end
        ss_low();
        spi_bits(16'h005A, 8, g);
        ss_high();
        cpu_rd(3'd1, v);
        checks++; if (v !== 8'h5A) begin errors++; $display("FAIL abort_next_rx got %h exp %h", v, 8'h5A); end
    endtask

    task automatic test_load_collision();
        logic [7:0]  v;
        logic [15:0] g1, g2;
        cpu_wr(3'd1, 8'h11);
        // The falling SS is seen three posedges after the pin; the fourth posedge is the LOAD cycle.
        @(negedge clk);
        sss = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; AD = 3'd1; DI = 8'h22;
        @(negedge clk);
        cs = 1'b0;
        cpu_rd(3'd2, v);
        checks++; if (v !== 8'h0D) begin errors++; $display("FAIL coll_status got %h exp %h", v, 8'h0D); end
        repeat (4) @(negedge clk);
        spi_bits(16'h0081, 8, g1);
        spi_bits(16'h0042, 8, g2);
        ss_high();
        checks++; if (g1[7:0] !== 8'h11) begin errors++; $display("FAIL coll_old got %h exp %h", g1[7:0], 8'h11); end
        checks++; if (g2[7:0] !== 8'h22) begin errors++; $display("FAIL coll_new got %h exp %h", g2[7:0], 8'h22); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  v;
        logic [15:0] g;
        cpu_rd(3'd1, v);
        checks++; if (v !== 8'h42) begin errors++; $display("FAIL mr_rx_pre got %h exp %h", v, 8'h42); end
        ss_low();
        spi_bits(16'h0005, 3, g);
        rst = 1'b0;
        #1;
        checks++; if (DO !== 8'h00) begin errors++; $display("FAIL mr_do got %h exp %h", DO, 8'h00); end
        checks++; if (smiso !== 1'b1) begin errors++; $display("FAIL mr_miso got %b exp 1", smiso); end
        checks++; if (smiso_oe !== 1'b0) begin errors++; $display("FAIL mr_oe got %b exp 0", smiso_oe); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mr_irq got %b exp 0", irq); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ss_high();
        ss_low();
        checks++; if (smiso_oe !== 1'b0) begin errors++; $display("FAIL mr_oe_en0 got %b exp 0", smiso_oe); end
        cpu_rd(3'd2, v);
        checks++; if (v !== 8'h24) begin errors++; $display("FAIL mr_status got %h exp %h", v, 8'h24); end
        cpu_rd(3'd1, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL mr_rx got %h exp %h", v, 8'h00); end
        ss_high();
    endtask

    initial begin
        rst = 1'b0; cs = 1'b0; rw = 1'b0; AD = '0; DI = '0;
        ssck = 1'b0; smosi = 1'b0; sss = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_frame8();
        test_frame16();
        test_back_to_back();
        test_abort();
        test_load_collision();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
